// File: rtl/btn_press_decoder.sv
// Classifies debounced button gestures into short, long and double presses,
// emitting one registered single-cycle pulse per gesture.
module btn_press_decoder #(
  parameter int LONG_CYCLES = 1000,
  parameter int DBL_GAP     = 300,
  parameter int CNT_W       = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic btn,
  output logic short_press,
  output logic long_press,
  output logic double_press,
  output logic hold,
  output logic busy
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_PRESS1,
    S_GAP,
    S_LONG_HOLD,
    S_RELEASE
  } state_t;

  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
  localparam logic [CNT_W-1:0] LONG_LAST = CNT_W'(LONG_CYCLES - 1);
  localparam logic [CNT_W-1:0] GAP_MAX   = CNT_W'(DBL_GAP);
  localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(DBL_GAP - 1);

  state_t           r_state;
  logic [CNT_W-1:0] r_cnt;
  logic             r_short;
  logic             r_long;
  logic             r_dbl;
  logic             r_hold;

  state_t           w_state;
  logic [CNT_W-1:0] w_cnt;
  logic             w_short;
  logic             w_long;
  logic             w_dbl;
  logic             w_hold;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_RELEASE;
      r_cnt   <= '0;
      r_short <= 1'b0;
      r_long  <= 1'b0;
      r_dbl   <= 1'b0;
      r_hold  <= 1'b0;
    end else begin
      r_state <= w_state;
      r_cnt   <= w_cnt;
      r_short <= w_short;
      r_long  <= w_long;
      r_dbl   <= w_dbl;
      r_hold  <= w_hold;
    end
  end

  // r_cnt holds the number of samples already seen at the current level,
  // so thresholds compare against the count that this edge would complete.
  always_comb begin
    w_state = r_state;
    w_cnt   = r_cnt;
    w_short = 1'b0;
    w_long  = 1'b0;
    w_dbl   = 1'b0;
    w_hold  = r_hold;
    case (r_state)
      S_IDLE: begin
        if (btn) begin
          w_state = S_PRESS1;
          w_cnt   = CNT_ONE;
        end
      end
      S_PRESS1: begin
        if (btn) begin
          if (r_cnt == LONG_LAST) begin
            w_long  = 1'b1;
            w_hold  = 1'b1;
            w_state = S_LONG_HOLD;
          end else begin
            w_cnt = r_cnt + CNT_ONE;
          end
        end else if (DBL_GAP == 1) begin
          // The release sample alone already fills a one-sample gap.
          w_short = 1'b1;
          w_state = S_IDLE;
        end else begin
          w_state = S_GAP;
          w_cnt   = CNT_ONE;
        end
      end
      S_GAP: begin
        if (btn && (r_cnt < GAP_MAX)) begin
          w_dbl   = 1'b1;
          w_state = S_RELEASE;
        end else if (!btn && (r_cnt == GAP_LAST)) begin
          w_short = 1'b1;
          w_state = S_IDLE;
        end else begin
          w_cnt = r_cnt + CNT_ONE;
        end
      end
      S_LONG_HOLD: begin
        if (!btn) begin
          w_hold  = 1'b0;
          w_state = S_IDLE;
        end
      end
      S_RELEASE: begin
        if (!btn) begin
          w_state = S_IDLE;
        end
      end
      default: begin
        w_state = S_RELEASE;
      end
    endcase
  end

  assign short_press  = r_short;
  assign long_press   = r_long;
  assign double_press = r_dbl;
  assign hold         = r_hold;
  assign busy         = (r_state != S_IDLE);

endmodule

// File: tb/tb_btn_press_decoder.sv
// Bench for btn_press_decoder: directed gesture scenarios plus random button
// traffic, checked every cycle against a gesture-level reference model.
module tb_btn_press_decoder;

  localparam int LONG_CYCLES = 8;
  localparam int DBL_GAP     = 4;
  localparam int CNT_W       = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic btn = 1'b0;
  logic short_press, long_press, double_press, hold, busy;

  int n_checks = 0;
  int n_errors = 0;
  int n_short, n_long, n_dbl;

  // Reference model: gesture bookkeeping in terms of run lengths.
  bit m_blocked;
  bit m_pending;
  bit m_long_done;
  bit m_hold;
  int m_high;
  int m_low;
  bit e_short, e_long, e_dbl;

  btn_press_decoder #(
    .LONG_CYCLES(LONG_CYCLES),
    .DBL_GAP    (DBL_GAP),
    .CNT_W      (CNT_W)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .btn         (btn),
    .short_press (short_press),
    .long_press  (long_press),
    .double_press(double_press),
    .hold        (hold),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int got, input int exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic model_edge(input bit b, input bit r);
    e_short = 1'b0;
    e_long  = 1'b0;
    e_dbl   = 1'b0;
    if (r) begin
      m_blocked   = 1'b1;
      m_pending   = 1'b0;
      m_long_done = 1'b0;
      m_hold      = 1'b0;
      m_high      = 0;
      m_low       = 0;
    end else if (m_blocked) begin
      if (!b) m_blocked = 1'b0;
    end else if (b) begin
      if (m_pending) begin
        e_dbl     = 1'b1;
        m_pending = 1'b0;
        m_blocked = 1'b1;
      end else begin
        m_high++;
        if (m_high == LONG_CYCLES && !m_long_done) begin
          e_long      = 1'b1;
          m_long_done = 1'b1;
          m_hold      = 1'b1;
        end
      end
    end else begin
      if (m_high > 0) begin
        if (!m_long_done) begin
          m_pending = 1'b1;
          m_low     = 1;
        end
        m_hold      = 1'b0;
        m_long_done = 1'b0;
        m_high      = 0;
      end else if (m_pending) begin
        m_low++;
      end
      if (m_pending && m_low == DBL_GAP) begin
        e_short   = 1'b1;
        m_pending = 1'b0;
      end
    end
  endtask

  function automatic int m_busy();
    return (m_blocked || m_pending || m_high > 0) ? 1 : 0;
  endfunction

  task automatic step(input bit b, input bit r);
    btn = b;
    rst = r;
    @(posedge clk);
    model_edge(b, r);
    @(negedge clk);
    chk("outputs", {short_press, long_press, double_press, hold, busy},
        {e_short, e_long, e_dbl, m_hold, m_busy() == 1});
    if (short_press + long_press + double_press > 1) chk("exclusive", 0, 1);
    n_short += int'(short_press);
    n_long  += int'(long_press);
    n_dbl   += int'(double_press);
  endtask

  task automatic run(input bit b, input int n);
    for (int i = 0; i < n; i++) step(b, 1'b0);
  endtask

  task automatic clr_counts();
    n_short = 0;
    n_long  = 0;
    n_dbl   = 0;
  endtask

  task automatic chk_counts(input string tag, input int s, input int l, input int d);
    chk({tag, "_short"}, n_short, s);
    chk({tag, "_long"}, n_long, l);
    chk({tag, "_double"}, n_dbl, d);
  endtask

  initial begin
    bit b;
    int len;
    clr_counts();
    @(negedge clk);

    // Reset with btn low, then the first edge leaves RELEASE.
    step(1'b0, 1'b1);
    step(1'b0, 1'b1);
    chk("rst_state", {short_press, long_press, double_press, hold, busy}, 5'b00001);
    step(1'b0, 1'b0);
    chk("busy_after_rst", busy, 0);
    run(1'b0, 2);

    clr_counts();
    run(1'b1, 3);
    run(1'b0, 3);
    chk("short_early", n_short, 0);
    run(1'b0, 1);
    chk("short_at_4th_low", short_press, 1);
    run(1'b0, 3);
    chk_counts("short", 1, 0, 0);

    clr_counts();
    run(1'b1, 7);
    run(1'b0, 6);
    chk_counts("press7", 1, 0, 0);

    clr_counts();
    run(1'b1, 8);
    chk("long_at_8th_high", long_press, 1);
    run(1'b1, 3);
    chk("hold_held", hold, 1);
    run(1'b0, 1);
    chk("hold_released", hold, 0);
    run(1'b0, 6);
    chk_counts("press8", 0, 1, 0);

    clr_counts();
    run(1'b1, 2);
    run(1'b0, 3);
    run(1'b1, 1);
    chk("dbl_at_first_high", double_press, 1);
    run(1'b1, 19);
    chk("dbl_busy_held", busy, 1);
    run(1'b0, 1);
    chk("dbl_busy_drop", busy, 0);
    run(1'b0, 4);
    chk_counts("double", 0, 0, 1);

    clr_counts();
    run(1'b1, 2);
    run(1'b0, 4);
    run(1'b1, 2);
    run(1'b0, 4);
    run(1'b0, 2);
    chk_counts("gap_boundary", 2, 0, 0);

    clr_counts();
    run(1'b1, 5);
    step(1'b1, 1'b1);
    run(1'b1, 20);
    run(1'b0, 6);
    chk_counts("rst_mid_press", 0, 0, 0);
    run(1'b1, 3);
    run(1'b0, 5);
    chk_counts("after_rst_press", 1, 0, 0);

    // Random button traffic with occasional resets.
    b = 1'b0;
    for (int i = 0; i < 300; i++) begin
      b = ~b;
      len = (b && $urandom_range(0, 3) == 0) ? $urandom_range(7, 12)
                                             : $urandom_range(1, 6);
      for (int k = 0; k < len; k++) step(b, ($urandom_range(0, 199) == 0));
    end
    run(1'b0, 8);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end

endmodule
